// File: rtl/mac_pkg.sv
// Shared constants and state encoding for the mac unit and its sequencer.
package mac_pkg;

    localparam int DATA_W  = 16;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 64;

    // Signed 8.8 fixed point unity.
    localparam logic [15:0] ONE = 16'h0100;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RESULT    = 2'd3
    } mac_state_e;

endpackage

// File: rtl/mac_seq_if.sv
// Host load/command/result port and mac-side operand port of mac_seq.
interface mac_seq_if #(
    parameter int DATA_W = mac_pkg::DATA_W,
    parameter int ADDR_W = mac_pkg::ADDR_W
);

    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_x;
    logic [DATA_W-1:0] ld_w;
    logic              cmd_valid;
    logic [ADDR_W:0]   cmd_len;
    logic              cmd_ready;
    logic              start;
    logic [DATA_W-1:0] mac_in;
    logic [DATA_W-1:0] weight;
    logic              done;
    logic [DATA_W-1:0] mac_out;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_err;

    modport slave (
        input  ld_en, ld_addr, ld_x, ld_w, cmd_valid, cmd_len, done, mac_out, res_ready,
        output cmd_ready, start, mac_in, weight, res_valid, res_data, res_err
    );

    modport master (
        output ld_en, ld_addr, ld_x, ld_w, cmd_valid, cmd_len, done, mac_out, res_ready,
        input  cmd_ready, start, mac_in, weight, res_valid, res_data, res_err
    );

endinterface

// File: rtl/mac_seq_vec_regfile.sv
// Vector register file: one synchronous write port, one combinational read port
// with write-through so a same-cycle write is seen by the reader.
module vec_regfile #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem_r[rd_addr];

endmodule

// File: rtl/mac_seq.sv
// Sequencer streaming x/w operand pairs into a mac unit and returning the
// captured dot product (or a timeout flag) over a valid/ready result port.
module mac_seq #(
    parameter int DATA_W  = mac_pkg::DATA_W,
    parameter int DEPTH   = mac_pkg::DEPTH,
    parameter int ADDR_W  = mac_pkg::ADDR_W,
    parameter int TIMEOUT = mac_pkg::TIMEOUT
) (
    input  logic      clk,
    input  logic      reset,
    mac_seq_if.slave  bus
);

    import mac_pkg::*;

    localparam int WAIT_W = $clog2(TIMEOUT);

    mac_state_e        state_r, state_s;
    logic [ADDR_W-1:0] idx_r, idx_s;
    logic [ADDR_W:0]   len_r, len_s;
    logic [WAIT_W-1:0] wait_r, wait_s;
    logic              start_r, start_s;
    logic [DATA_W-1:0] mac_in_r, mac_in_s;
    logic [DATA_W-1:0] weight_r, weight_s;
    logic              res_valid_r, res_valid_s;
    logic [DATA_W-1:0] res_data_r, res_data_s;
    logic              res_err_r, res_err_s;

    logic              wr_en_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [DATA_W-1:0] x_rd_s, w_rd_s;
    logic [ADDR_W:0]   len_clamp_s;

    // Loads are only honoured while idle; the read port looks one pair ahead
    // because the output registers hold the pair currently on the bus.
    assign wr_en_s     = bus.ld_en && (state_r == ST_IDLE);
    assign rd_addr_s   = (state_r == ST_ISSUE) ? (idx_r + ADDR_W'(1)) : ADDR_W'(0);
    assign len_clamp_s = (bus.cmd_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : bus.cmd_len;

    vec_regfile #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_x_rf (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (bus.ld_addr),
        .wr_data (bus.ld_x),
        .rd_addr (rd_addr_s),
        .rd_data (x_rd_s)
    );

    vec_regfile #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_w_rf (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (bus.ld_addr),
        .wr_data (bus.ld_w),
        .rd_addr (rd_addr_s),
        .rd_data (w_rd_s)
    );

    // Next-state and next-output logic for the sequencer FSM.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        len_s       = len_r;
        wait_s      = wait_r;
        start_s     = 1'b0;
        mac_in_s    = '0;
        weight_s    = '0;
        res_valid_s = res_valid_r;
        res_data_s  = res_data_r;
        res_err_s   = res_err_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    len_s = len_clamp_s;
                    if (len_clamp_s == (ADDR_W+1)'(0)) begin
                        state_s     = ST_RESULT;
                        res_valid_s = 1'b1;
                        res_data_s  = '0;
                        res_err_s   = 1'b0;
                    end else begin
                        state_s  = ST_ISSUE;
                        idx_s    = '0;
                        start_s  = 1'b1;
                        mac_in_s = x_rd_s;
                        weight_s = w_rd_s;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if ({1'b0, idx_r} == (len_r - (ADDR_W+1)'(1))) begin
                    state_s = ST_WAIT_DONE;
                    wait_s  = '0;
                end else begin
                    idx_s    = idx_r + ADDR_W'(1);
                    mac_in_s = x_rd_s;
                    weight_s = w_rd_s;
                end
            end
            ST_WAIT_DONE: begin
                // done takes priority over an expiring timeout
                if (bus.done) begin
                    state_s     = ST_RESULT;
                    res_valid_s = 1'b1;
                    res_data_s  = bus.mac_out;
                    res_err_s   = 1'b0;
                end else if (wait_r == WAIT_W'(TIMEOUT - 1)) begin
                    state_s     = ST_RESULT;
                    res_valid_s = 1'b1;
                    res_data_s  = '0;
                    res_err_s   = 1'b1;
                end else begin
                    wait_s = wait_r + WAIT_W'(1);
                end
            end
            ST_RESULT: begin
                if (bus.res_ready) begin
                    state_s     = ST_IDLE;
                    res_valid_s = 1'b0;
                end else begin
                    state_s = ST_RESULT;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                res_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            len_r       <= '0;
            wait_r      <= '0;
            start_r     <= 1'b0;
            mac_in_r    <= '0;
            weight_r    <= '0;
            res_valid_r <= 1'b0;
            res_data_r  <= '0;
            res_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            len_r       <= len_s;
            wait_r      <= wait_s;
            start_r     <= start_s;
            mac_in_r    <= mac_in_s;
            weight_r    <= weight_s;
            res_valid_r <= res_valid_s;
            res_data_r  <= res_data_s;
            res_err_r   <= res_err_s;
        end
    end

    assign bus.cmd_ready = (state_r == ST_IDLE);
    assign bus.start     = start_r;
    assign bus.mac_in    = mac_in_r;
    assign bus.weight    = weight_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_data  = res_data_r;
    assign bus.res_err   = res_err_r;

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq: the bench plays both host and mac unit, and
// samples on the falling edge, driving inputs for the next rising edge.
module tb_mac_seq;

    import mac_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mac_seq_if bus ();

    mac_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic mac_done(input logic [15:0] value);
        bus.done    = 1'b1;
        bus.mac_out = value;
        tick();
        bus.done    = 1'b0;
        bus.mac_out = 16'h0000;
    endtask

    task automatic res_handshake();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++; if ({bus.cmd_ready, bus.start, bus.res_valid, bus.res_err} !== 4'b1000) begin errors++; $display("FAIL reset_flags got %b exp %b", {bus.cmd_ready, bus.start, bus.res_valid, bus.res_err}, 4'b1000); end
        checks++; if (bus.mac_in !== 16'h0000) begin errors++; $display("FAIL reset_mac_in got %h exp %h", bus.mac_in, 16'h0000); end
        checks++; if (bus.weight !== 16'h0000) begin errors++; $display("FAIL reset_weight got %h exp %h", bus.weight, 16'h0000); end
        checks++; if (bus.res_data !== 16'h0000) begin errors++; $display("FAIL reset_res_data got %h exp %h", bus.res_data, 16'h0000); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.ld_en = 1'b1; bus.ld_addr = 4'd0; bus.ld_x = ONE; bus.ld_w = ONE;
        tick();
        bus.ld_en = 1'b0;
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL single_cmd_ready got %b exp %b", bus.cmd_ready, 1'b1); end
        bus.cmd_valid = 1'b1; bus.cmd_len = 5'd1;
        tick();
        bus.cmd_valid = 1'b0;
        checks++; if ({bus.start, bus.cmd_ready} !== 2'b10) begin errors++; $display("FAIL single_start got %b exp %b", {bus.start, bus.cmd_ready}, 2'b10); end
        checks++; if ({bus.mac_in, bus.weight} !== {ONE, ONE}) begin errors++; $display("FAIL single_pair got %h exp %h", {bus.mac_in, bus.weight}, {ONE, ONE}); end
        tick();
        checks++; if ({bus.start, bus.mac_in, bus.weight} !== 33'd0) begin errors++; $display("FAIL single_idle_bus got %h exp %h", {bus.start, bus.mac_in, bus.weight}, 33'd0); end
        tick();
        tick();
        mac_done(ONE);
        checks++; if ({bus.res_valid, bus.res_err, bus.res_data} !== {2'b10, ONE}) begin errors++; $display("FAIL single_result got %h exp %h", {bus.res_valid, bus.res_err, bus.res_data}, {2'b10, ONE}); end
        res_handshake();
        checks++; if ({bus.cmd_ready, bus.res_valid} !== 2'b10) begin errors++; $display("FAIL single_back_idle got %b exp %b", {bus.cmd_ready, bus.res_valid}, 2'b10); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            bus.ld_en = 1'b1; bus.ld_addr = 4'(i); bus.ld_x = 16'h0100; bus.ld_w = 16'h0200;
            tick();
        end
        bus.ld_en = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_len = 5'd4;
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({bus.start, bus.mac_in, bus.weight} !== {(i == 0), 16'h0100, 16'h0200}) begin errors++; $display("FAIL b2b_pair%0d got %h exp %h", i, {bus.start, bus.mac_in, bus.weight}, {(i == 0), 16'h0100, 16'h0200}); end
            tick();
        end
        checks++; if ({bus.start, bus.mac_in} !== 17'd0) begin errors++; $display("FAIL b2b_after got %h exp %h", {bus.start, bus.mac_in}, 17'd0); end
        mac_done(16'h0800);
        checks++; if ({bus.res_valid, bus.res_err, bus.res_data} !== {2'b10, 16'h0800}) begin errors++; $display("FAIL b2b_result got %h exp %h", {bus.res_valid, bus.res_err, bus.res_data}, {2'b10, 16'h0800}); end
        res_handshake();
    endtask

    task automatic test_timeout();
        int n;
        bus.cmd_valid = 1'b1; bus.cmd_len = 5'd5;
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++; if ({bus.res_valid, bus.start} !== 2'b00) begin errors++; $display("FAIL timeout_wait_entry got %b exp %b", {bus.res_valid, bus.start}, 2'b00); end
        n = 0;
        while (bus.res_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++; if (n !== TIMEOUT) begin errors++; $display("FAIL timeout_latency got %0d exp %0d", n, TIMEOUT); end
        checks++; if ({bus.res_err, bus.res_data} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL timeout_result got %h exp %h", {bus.res_err, bus.res_data}, {1'b1, 16'h0000}); end
        res_handshake();
    endtask

    task automatic test_len_zero();
        bus.cmd_valid = 1'b1; bus.cmd_len = 5'd0;
        tick();
        checks++; if ({bus.start, bus.res_valid, bus.res_err, bus.res_data} !== {3'b010, 16'h0000}) begin errors++; $display("FAIL len0_result got %h exp %h", {bus.start, bus.res_valid, bus.res_err, bus.res_data}, {3'b010, 16'h0000}); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if ({bus.cmd_ready, bus.start, bus.res_valid, bus.res_err, bus.res_data} !== {4'b0010, 16'h0000}) begin errors++; $display("FAIL len0_hold%0d got %h exp %h", i, {bus.cmd_ready, bus.start, bus.res_valid, bus.res_err, bus.res_data}, {4'b0010, 16'h0000}); end
        end
        bus.cmd_valid = 1'b0;
        res_handshake();
        checks++; if ({bus.cmd_ready, bus.res_valid} !== 2'b10) begin errors++; $display("FAIL len0_release got %b exp %b", {bus.cmd_ready, bus.res_valid}, 2'b10); end
    endtask

    task automatic test_clamp();
        for (int i = 0; i < 16; i++) begin
            bus.ld_en = 1'b1; bus.ld_addr = 4'(i); bus.ld_x = 16'(i + 1); bus.ld_w = 16'(16'h1000 + i);
            tick();
        end
        bus.ld_en = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_len = 5'd20;
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++; if ({bus.start, bus.mac_in, bus.weight} !== {(i == 0), 16'(i + 1), 16'(16'h1000 + i)}) begin errors++; $display("FAIL clamp_pair%0d got %h exp %h", i, {bus.start, bus.mac_in, bus.weight}, {(i == 0), 16'(i + 1), 16'(16'h1000 + i)}); end
            tick();
        end
        checks++; if ({bus.start, bus.mac_in, bus.weight} !== 33'd0) begin errors++; $display("FAIL clamp_after got %h exp %h", {bus.start, bus.mac_in, bus.weight}, 33'd0); end
        mac_done(16'hABCD);
        checks++; if ({bus.res_valid, bus.res_err, bus.res_data} !== {2'b10, 16'hABCD}) begin errors++; $display("FAIL clamp_result got %h exp %h", {bus.res_valid, bus.res_err, bus.res_data}, {2'b10, 16'hABCD}); end
        res_handshake();
    endtask

    task automatic test_reset_mid();
        bus.cmd_valid = 1'b1; bus.cmd_len = 5'd8;
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({bus.mac_in, bus.weight} !== {16'(i + 1), 16'(16'h1000 + i)}) begin errors++; $display("FAIL rstmid_pair%0d got %h exp %h", i, {bus.mac_in, bus.weight}, {16'(i + 1), 16'(16'h1000 + i)}); end
            if (i < 2) tick();
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if ({bus.cmd_ready, bus.start, bus.res_valid, bus.mac_in, bus.weight} !== {3'b100, 32'd0}) begin errors++; $display("FAIL rstmid_outputs got %h exp %h", {bus.cmd_ready, bus.start, bus.res_valid, bus.mac_in, bus.weight}, {3'b100, 32'd0}); end
        bus.done = 1'b1; bus.mac_out = 16'h5555;
        tick();
        tick();
        bus.done = 1'b0; bus.mac_out = 16'h0000;
        checks++; if ({bus.cmd_ready, bus.res_valid} !== 2'b10) begin errors++; $display("FAIL rstmid_stray_done got %b exp %b", {bus.cmd_ready, bus.res_valid}, 2'b10); end
    endtask

    task automatic test_write_at_accept();
        bus.ld_en = 1'b1; bus.ld_addr = 4'd0; bus.ld_x = 16'h1234; bus.ld_w = 16'h4321;
        bus.cmd_valid = 1'b1; bus.cmd_len = 5'd1;
        tick();
        bus.ld_en = 1'b0; bus.cmd_valid = 1'b0;
        checks++; if ({bus.start, bus.mac_in, bus.weight} !== {1'b1, 16'h1234, 16'h4321}) begin errors++; $display("FAIL wr_accept_pair got %h exp %h", {bus.start, bus.mac_in, bus.weight}, {1'b1, 16'h1234, 16'h4321}); end
        tick();
        mac_done(16'h0001);
        checks++; if ({bus.res_valid, bus.res_data} !== {1'b1, 16'h0001}) begin errors++; $display("FAIL wr_accept_result got %h exp %h", {bus.res_valid, bus.res_data}, {1'b1, 16'h0001}); end
        res_handshake();
    endtask

    task automatic test_dropped_write();
        bus.cmd_valid = 1'b1; bus.cmd_len = 5'd1;
        tick();
        bus.cmd_valid = 1'b0;
        bus.ld_en = 1'b1; bus.ld_addr = 4'd0; bus.ld_x = 16'h7FFF; bus.ld_w = 16'h7FFF;
        tick();
        tick();
        bus.ld_en = 1'b0;
        mac_done(16'h0002);
        res_handshake();
        bus.cmd_valid = 1'b1; bus.cmd_len = 5'd1;
        tick();
        bus.cmd_valid = 1'b0;
        checks++; if ({bus.start, bus.mac_in, bus.weight} !== {1'b1, 16'h1234, 16'h4321}) begin errors++; $display("FAIL drop_pair got %h exp %h", {bus.start, bus.mac_in, bus.weight}, {1'b1, 16'h1234, 16'h4321}); end
        tick();
        mac_done(16'h0003);
        checks++; if ({bus.res_valid, bus.res_data} !== {1'b1, 16'h0003}) begin errors++; $display("FAIL drop_result got %h exp %h", {bus.res_valid, bus.res_data}, {1'b1, 16'h0003}); end
        res_handshake();
    endtask

    initial begin
        bus.ld_en = 1'b0; bus.ld_addr = 4'd0; bus.ld_x = 16'h0000; bus.ld_w = 16'h0000;
        bus.cmd_valid = 1'b0; bus.cmd_len = 5'd0;
        bus.done = 1'b0; bus.mac_out = 16'h0000; bus.res_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_len_zero();
        test_clamp();
        test_reset_mid();
        test_write_at_accept();
        test_dropped_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mac_seq.md
# mac_seq

Sequencer that drives the `mac` unit from the initiator side. It holds an input vector and a weight vector in local register files and, on command, streams operand pairs into `mac` with the `start` framing pulse. It then waits for `done`, captures `mac_out`, and presents the dot-product result to the host through a valid/ready port. It sits between the layer controller and a `mac` instance, one `mac_seq` per MAC.

## Interface
- `DATA_W`, 16: operand/result width, signed 8.8 fixed point (0x0100 = 1.0)
- `DEPTH`, 16: vector register-file depth
- `ADDR_W`, 4: log2(DEPTH)
- `TIMEOUT`, 64: max cycles to wait for `done`

- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-low; logic resets on a rising edge where `reset`==0
- `ld_en` in 1: operand write strobe
- `ld_addr` in ADDR_W: write index
- `ld_x` in DATA_W: input element written to x[ld_addr]
- `ld_w` in DATA_W: weight element written to w[ld_addr]
- `cmd_valid` in 1: run request
- `cmd_len` in ADDR_W+1: number of pairs, 0..DEPTH
- `cmd_ready` out 1: high only in IDLE
- `start` out 1: to `mac`; one-cycle frame pulse coincident with the first pair
- `mac_in` out DATA_W: to `mac`, input operand
- `weight` out DATA_W: to `mac`, weight operand
- `done` in 1: from `mac`; result valid on `mac_out` this cycle
- `mac_out` in DATA_W: from `mac`
- `res_valid` out 1: result available
- `res_ready` in 1: host accepts result
- `res_data` out DATA_W: captured dot product
- `res_err` out 1: timeout flag, qualified by `res_valid`

## Operation
- States: IDLE, ISSUE, WAIT_DONE, RESULT.
- IDLE: `cmd_ready`=1. A `ld_en` write updates x/w at the edge. `ld_en` in any other state is dropped.
- Command accept is `cmd_valid && cmd_ready`. The length is latched; `cmd_len` > DEPTH clamps to DEPTH.
  - `cmd_len`==0: go to RESULT with `res_data`=0 and `res_err`=0. No `start` is issued.
  - Otherwise: go to ISSUE with index=0.
- ISSUE: every cycle drives `mac_in`=x[idx] and `weight`=w[idx]. `start`=1 only when idx==0. idx increments each cycle. After idx==len-1, go to WAIT_DONE.
- WAIT_DONE: the wait counter starts at 0 and increments each cycle.
  - On `done`==1: capture `mac_out` into `res_data`, set `res_err`=0, go to RESULT.
  - If the counter reaches TIMEOUT-1 without `done`: set `res_data`=0, `res_err`=1, go to RESULT.
  - `done` and timeout in the same cycle: `done` wins.
- RESULT: `res_valid`=1 and `res_data`/`res_err` are held stable. When `res_ready`==1, go to IDLE.
- `done` outside WAIT_DONE is ignored.
- `mac_in`, `weight` and `start` are 0 in every state other than ISSUE.
- No arithmetic is performed here. Data passes through bit-exact and is never saturated or rounded.

## Timing
- Reset values: state=IDLE, `cmd_ready`=1 (combinational from state), `start`=0, `mac_in`=0, `weight`=0, `res_valid`=0, `res_data`=0, `res_err`=0. x/w contents are not cleared.
- `start`, `mac_in` and `weight` are registered.
  - The first pair and `start` appear in the cycle after command accept.
  - Pairs appear on consecutive cycles with no bubbles. ISSUE lasts exactly `len` cycles.
- A write in the same cycle as command accept is visible to the issue stream (write first, read next cycle).
- `res_valid` rises in the cycle after `done` is sampled. The earliest new `cmd_ready` is the cycle after the `res_ready` handshake.
- Reset asserted mid-ISSUE or mid-WAIT_DONE: the next cycle is IDLE with all outputs at reset values. A later `done` from the MAC is ignored.
- `cmd_valid` held high in RESULT has no effect.

## Structure
- Shared package `mac_pkg`: DATA_W, the fixed-point ONE constant (16'h0100), and the state encoding enum shared with the `mac` docs.
- One natural sub-module: `vec_regfile` (DEPTH x DATA_W, 1 write port, 1 read port), instantiated twice for x and w.
- The FSM, index counter and timeout counter live in `mac_seq`.

## Test plan
- Load x[0]=w[0]=0x0100, run `cmd_len`=1, `mac` model returns done with 0x0100 three cycles later → one `start` pulse with 0x0100/0x0100, then `res_valid` with `res_data`=0x0100 and `res_err`=0.
- Load x[0..3]=0x0100, w[0..3]=0x0200, run `cmd_len`=4 → `start` only on the first of 4 back-to-back pairs; model done=0x0800 → `res_data`=0x0800.
- Run `cmd_len`=5, never assert `done` → `res_valid` exactly TIMEOUT cycles after entering WAIT_DONE, `res_err`=1, `res_data`=0.
- Run `cmd_len`=0 → no `start` pulse, `res_valid` next cycle with `res_data`=0; hold `res_ready`=0 for 5 cycles → output stable and `cmd_ready`=0 throughout.
- Assert `reset`=0 on the 3rd ISSUE cycle of a len=8 run → next cycle `start`/`mac_in`/`weight`=0 and `cmd_ready`=1. A stray `done` afterwards does not raise `res_valid`.
- `ld_en` during ISSUE to x[0]=0x7FFF, then rerun `cmd_len`=1 → the old x[0] value is streamed (the write was dropped).
